// File: rtl/rand_seq_buf_pkg.sv
// Shared types and defaults for the random target-sequence buffer.
package rand_seq_pkg;

  localparam int SEQ_WIDTH = 4;
  localparam int SEQ_DEPTH = 8;
  localparam int SEQ_RANGE = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } rand_seq_state_e;

  // Requested lengths above the buffer depth are cut down to the depth.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int depth);
    if (int'(len) > depth) return 4'(depth);
    return len;
  endfunction

endpackage

// File: rtl/rand_seq_buf_if.sv
// Output stream of the sequence buffer: valid/ready handshake plus data.
interface rand_seq_buf_if
  import rand_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/rand_seq_buf_seq_fifo.sv
// Synchronous FIFO holding one target sequence. clr empties it in one
// edge; a push while full and a pop while empty are dropped.
module seq_fifo
  import rand_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DEPTH = SEQ_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy bookkeeping; clear has priority over traffic.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rand_seq_buf.sv
// Builds a sequence of random grid targets from an upstream LFSR and plays
// it out over a valid/ready stream.
// Optional feature: define RAND_SEQ_NO_REPEAT_EN to reject a value equal to
// the previously accepted entry of the same sequence.
//
// state | meaning
// IDLE  | waiting for a start with non-zero length
// FILL  | sampling rand_val, storing accepted values until target reached
// DRAIN | presenting stored entries oldest-first until the buffer is empty
module rand_seq_buf
  import rand_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DEPTH = SEQ_DEPTH,
  parameter int RANGE = SEQ_RANGE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      rand_val,
  input  logic                  start,
  input  logic [3:0]            seq_len,
  input  logic                  abort,
  rand_seq_buf_if.master        out_if,
  output logic                  busy,
  output logic [3:0]            count,
  output logic                  done
);

  localparam int CW = $clog2(DEPTH + 1);

  rand_seq_state_e  state;
  rand_seq_state_e  state_nxt;
  logic [3:0]       target_len;
  logic             done_q;
  logic [CW-1:0]    fifo_cnt;
  logic [3:0]       cnt4;
  logic [WIDTH-1:0] head;
  logic             start_ok;
  logic             eligible;
  logic             push;
  logic             pop;
  logic             clr;
  logic             valid_c;

  assign cnt4     = 4'(fifo_cnt);
  assign start_ok = start && (seq_len != 4'd0);

`ifdef RAND_SEQ_NO_REPEAT_EN
  logic [WIDTH-1:0] last_acc;
  logic             have_last;

  assign eligible = (32'(rand_val) < 32'(RANGE)) &&
                    (!have_last || (rand_val != last_acc));

  // Remember the last accepted value; forgotten whenever the buffer clears.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      last_acc  <= '0;
      have_last <= 1'b0;
    end else if (push) begin
      last_acc  <= rand_val;
      have_last <= 1'b1;
    end
  end
`else
  assign eligible = (32'(rand_val) < 32'(RANGE));
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; abort overrides everything except reset.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nxt = FILL;
        FILL:    if (cnt4 == target_len) state_nxt = DRAIN;
        DRAIN:   if (pop && (cnt4 == 4'd1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-state control outputs to the FIFO and the stream.
  always_comb begin
    busy    = (state != IDLE);
    valid_c = (state == DRAIN) && (cnt4 != 4'd0);
    push    = (state == FILL) && !abort && eligible && (cnt4 < target_len);
    pop     = valid_c && out_if.out_ready && !abort;
    clr     = abort || ((state == IDLE) && start_ok);
  end

  // Target length capture and the one-cycle done pulse after the last pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_len <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= pop && (cnt4 == 4'd1);
      if (abort)                          target_len <= 4'd0;
      else if ((state == IDLE) && start_ok) target_len <= clamp_len(seq_len, DEPTH);
    end
  end

  seq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .din   (rand_val),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt)
  );

  assign out_if.out_valid = valid_c;
  assign out_if.out_data  = valid_c ? head : '0;
  assign count            = cnt4;
  assign done             = done_q;

endmodule
